ntt_poly_feeder: RTL and testbench
==================================

Name: ntt_poly_feeder

Overview:
- Upstream stage of the 4-BU butterfly datapath. Holds one 256-coefficient polynomial as 32 words of 96 bits, each word holding 8 x 12-bit coefficients, in an internal RAM.
- For each NTT/INTT layer it streams words to the butterfly in layer-dependent pair order, tagged with stage/type, and writes the processed words back in place.
- Also provides host-side load and dump ports with valid/ready handshakes.

Parameters:
- WB_TIMEOUT, 64, max cycles allowed in WAIT_WB without a wb_valid before err is raised.
- DEPTH_LOG2, 5, log2 of the word count; fixed at 5 (32 words).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start_load  in  1  pulse: begin LOAD
- ld_valid  in  1  load word valid
- ld_data  in  96  load word, coefficient i at bits [12i+11:12i]
- ld_ready  out  1  high in LOAD
- start_run  in  1  pulse: process one layer
- run_stage  in  3  layer 0..6, sampled with start_run
- bf_data  out  96  word to butterfly
- bf_valid  out  1  bf_data/bf_stage/bf_type valid
- bf_stage  out  3  latched run_stage
- bf_type  out  1  0 = first word of a pair (low address), 1 = partner
- wb_valid  in  1  processed word valid
- wb_data  in  96  processed word
- start_dump  in  1  pulse: begin DUMP
- dump_valid  out  1  dump word valid
- dump_data  out  96  dump word
- dump_ready  in  1  consumer accepts
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of LOAD, RUN or DUMP
- err  out  1  sticky error flag, cleared only by rst

Behaviour:
- States: IDLE, LOAD, ISSUE, WAIT_WB, DUMP.
- Reset: state = IDLE; all outputs 0; counters 0. RAM contents are not reset.
- IDLE:
  - start_load -> LOAD.
  - else start_run -> ISSUE.
  - else start_dump -> DUMP.
  - Priority when pulses coincide: load > run > dump.
  - start_* pulses seen outside IDLE are ignored.
- LOAD:
  - ld_ready = 1.
  - Each ld_valid writes word wcnt, then wcnt increments.
  - After word 31: done pulse, return to IDLE.
- ISSUE:
  - One RAM read per cycle for 32 cycles. No backpressure.
  - The RAM has a 1-cycle synchronous read, so bf_valid is asserted one cycle after each address.
- Issue order for stage s in 0..4:
  - d = 16 >> s.
  - For pair index k = 0..15: j = k with a 0 bit inserted at bit position log2(d).
  - Emit address j (type 0), then j + d (type 1).
  - Example, s = 0: 0, 16, 1, 17, ..., 15, 31.
- Issue order for stage 5 or 6: addresses 0..31 sequentially, type 0.
- Stage value 7: err is set, no issue, return to IDLE immediately.
- Write-back:
  - A second, identical address generator advances on each wb_valid.
  - Each wb_data is written to the current generator address.
  - wb_valid may arrive during ISSUE.
  - RAM is dual-port: port A is used for read/issue, port B for write-back.
- Read-during-write to the same address: the read returns the old data. The pair order guarantees this never occurs within one layer.
- WAIT_WB:
  - Entered after the 32nd issue.
  - When the 32nd write-back lands: done pulse, return to IDLE.
  - If no wb_valid arrives for WB_TIMEOUT cycles: set err, return to IDLE.
- wb_valid outside ISSUE/WAIT_WB: ignored and sets err.
- DUMP:
  - Registered output that holds dump_data/dump_valid while dump_ready = 0.
  - Words are presented in order 0..31.
  - After word 31 is accepted: done pulse, return to IDLE.

Optional Feature:
- PERF_CNT_EN defined:
  - Adds output perf_cycles [15:0].
  - It counts cycles from entry into ISSUE to the done pulse of RUN and holds that value until the next run.
  - Reset value 0.
- PERF_CNT_EN undefined: the port and counter are absent.

Decomposition:
- Shared package ntt_pkg:
  - Q = 3329, COEF_W = 12, WORD_W = 96, NWORDS = 32.
  - State enum.
  - Stage codes 0..6.
- Sub-module ntt_pair_addr_gen: inputs stage, k, type; output 5-bit address. It is combinational and instantiated twice (issue and write-back).
- The RAM is inferred inline.

Test Plan:
- Load 32 words where word n has all coefficients = n. Dump with dump_ready always high -> dump_data of word n = {8{n}}, 32 dump_valid beats, done pulse.
- start_run, stage 0, with wb_data = bf_data looped back after 6 cycles -> bf addresses 0, 16, 1, 17, ..., 15, 31, bf_type alternating 0/1. After the 32nd write-back, done pulses and dump equals the load.
- Stage 3 (d = 2) -> bf sequence begins with words 0, 2, 1, 3, 4, 6.
- Stage 6 -> sequential 0..31, all bf_type = 0.
- Write-back returns ~word -> dump shows the inverted words.
- Assert rst mid-ISSUE -> outputs drop to 0 asynchronously. After release, a new load/dump works.
- Dump with dump_ready toggling 1010... -> no words lost or duplicated, and dump_data is stable while stalled.
- Stage 7 -> err = 1, no bf_valid. No write-back for 64 cycles in WAIT_WB -> err = 1, state returns to IDLE.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT polynomial feeder and its helpers.
package ntt_pkg;

    localparam int Q      = 3329;
    localparam int COEF_W = 12;
    localparam int NCOEF  = 8;
    localparam int WORD_W = COEF_W * NCOEF;
    localparam int NWORDS = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_WB = 3'd3,
        ST_DUMP    = 3'd4
    } state_t;

    // Stages 0..4 walk butterfly pairs at distance 16 >> stage; 5 and 6 stream linearly.
    localparam logic [2:0] STAGE_LAST_PAIRED = 3'd4;
    localparam logic [2:0] STAGE_LAST        = 3'd6;
    localparam logic [2:0] STAGE_INVALID     = 3'd7;

endpackage

// File: rtl/ntt_poly_feeder_if.sv
// Load, butterfly issue/write-back and dump buses of the NTT polynomial feeder.
interface ntt_poly_feeder_if;
    import ntt_pkg::*;

    logic              ld_valid;
    logic [WORD_W-1:0] ld_data;
    logic              ld_ready;

    logic [WORD_W-1:0] bf_data;
    logic              bf_valid;
    logic [2:0]        bf_stage;
    logic              bf_type;

    logic              wb_valid;
    logic [WORD_W-1:0] wb_data;

    logic              dump_valid;
    logic [WORD_W-1:0] dump_data;
    logic              dump_ready;

    modport master (
        input  ld_valid, ld_data,
        output ld_ready,
        output bf_data, bf_valid, bf_stage, bf_type,
        input  wb_valid, wb_data,
        output dump_valid, dump_data,
        input  dump_ready
    );

    modport slave (
        output ld_valid, ld_data,
        input  ld_ready,
        input  bf_data, bf_valid, bf_stage, bf_type,
        output wb_valid, wb_data,
        input  dump_valid, dump_data,
        output dump_ready
    );

endinterface

// File: rtl/ntt_pair_addr_gen.sv
// Maps (stage, pair index k, pair member) to a word address by inserting the
// member bit into k at bit position log2(16 >> stage); stages 5/6 reduce to {k, member}.
module ntt_pair_addr_gen
    import ntt_pkg::*;
(
    input  logic [2:0] stage,
    input  logic [3:0] k,
    input  logic       pair_type,
    output logic [4:0] addr
);

    logic [4:0] kx;
    logic [4:0] ins [5];
    logic [2:0] pos;

    assign kx = {1'b0, k};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_ins
            assign ins[gi] = ((kx >> gi) << (gi + 1))
                           | (5'(pair_type) << gi)
                           | (kx & 5'((1 << gi) - 1));
        end
    endgenerate

    always_comb begin
        pos = 3'd0;
        if (stage <= STAGE_LAST_PAIRED) begin
            pos = 3'd4 - stage;
        end
        addr = ins[pos];
    end

endmodule

// File: rtl/ntt_poly_feeder.sv
// Holds one 32x96-bit polynomial and streams it to the butterfly per layer with in-place write-back.
// Optional: define PERF_CNT_EN to add the perf_cycles run-length counter output.
module ntt_poly_feeder
    import ntt_pkg::*;
#(
    parameter int WB_TIMEOUT = 64,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_load,
    input  logic               start_run,
    input  logic [2:0]         run_stage,
    input  logic               start_dump,
    ntt_poly_feeder_if.master  bus,
    output logic               busy,
    output logic               done,
`ifdef PERF_CNT_EN
    output logic [15:0]        perf_cycles,
`endif
    output logic               err
);

    localparam int AW   = DEPTH_LOG2;
    localparam int TO_W = $clog2(WB_TIMEOUT + 1);
    localparam logic [AW-1:0]   LAST_WORD = AW'(NWORDS - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(WB_TIMEOUT - 1);

    state_t          state_reg, state_next;
    logic [AW-1:0]   cnt_reg, cnt_next;
    logic [AW-1:0]   iss_reg, iss_next;
    logic [AW:0]     wb_reg, wb_next;
    logic [TO_W-1:0] to_reg, to_next;
    logic [2:0]      stage_reg, stage_next;
    logic            bfv_reg, bfv_next;
    logic            bft_reg, bft_next;
    logic            dv_reg, dv_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;

    logic [WORD_W-1:0] mem [NWORDS];
    logic [WORD_W-1:0] rd_q;
    logic [AW-1:0]     rd_addr;
    logic              we;
    logic [AW-1:0]     wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              wb_take;

    logic [AW-1:0] iss_addr, wb_addr;

    ntt_pair_addr_gen u_iss_gen (
        .stage     (stage_reg),
        .k         (iss_reg[4:1]),
        .pair_type (iss_reg[0]),
        .addr      (iss_addr)
    );

    ntt_pair_addr_gen u_wb_gen (
        .stage     (stage_reg),
        .k         (wb_reg[4:1]),
        .pair_type (wb_reg[0]),
        .addr      (wb_addr)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        iss_next   = iss_reg;
        wb_next    = wb_reg;
        to_next    = to_reg;
        stage_next = stage_reg;
        bfv_next   = 1'b0;
        bft_next   = 1'b0;
        dv_next    = 1'b0;
        done_next  = 1'b0;
        err_next   = err_reg;
        rd_addr    = '0;
        we         = 1'b0;
        wr_addr    = cnt_reg;
        wr_data    = bus.ld_data;
        wb_take    = 1'b0;

        // Write-back owns RAM port B whenever a layer is in flight.
        if (bus.wb_valid) begin
            if ((state_reg == ST_ISSUE || state_reg == ST_WAIT_WB) && !wb_reg[AW]) begin
                wb_take = 1'b1;
                we      = 1'b1;
                wr_addr = wb_addr;
                wr_data = bus.wb_data;
                wb_next = wb_reg + 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (start_load) begin
                    state_next = ST_LOAD;
                    cnt_next   = '0;
                end else if (start_run) begin
                    if (run_stage == STAGE_INVALID) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = ST_ISSUE;
                        stage_next = run_stage;
                        iss_next   = '0;
                        wb_next    = '0;
                    end
                end else if (start_dump) begin
                    state_next = ST_DUMP;
                    cnt_next   = '0;
                end
            end
            ST_LOAD: begin
                if (bus.ld_valid) begin
                    we       = 1'b1;
                    wr_addr  = cnt_reg;
                    wr_data  = bus.ld_data;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_WORD) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_ISSUE: begin
                rd_addr  = iss_addr;
                bfv_next = 1'b1;
                bft_next = (stage_reg <= STAGE_LAST_PAIRED) ? iss_reg[0] : 1'b0;
                iss_next = iss_reg + 1'b1;
                if (iss_reg == LAST_WORD) begin
                    state_next = ST_WAIT_WB;
                    to_next    = '0;
                end
            end
            ST_WAIT_WB: begin
                if (wb_take) begin
                    to_next = '0;
                    if (wb_reg == {1'b0, LAST_WORD}) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (wb_reg[AW]) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else if (to_reg == TO_LAST) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    to_next = to_reg + 1'b1;
                end
            end
            ST_DUMP: begin
                // Re-reading the presented address keeps dump_data steady while stalled.
                dv_next = 1'b1;
                rd_addr = cnt_reg;
                if (dv_reg && bus.dump_ready) begin
                    if (cnt_reg == LAST_WORD) begin
                        done_next  = 1'b1;
                        dv_next    = 1'b0;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                        rd_addr  = cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            iss_reg   <= '0;
            wb_reg    <= '0;
            to_reg    <= '0;
            stage_reg <= '0;
            bfv_reg   <= 1'b0;
            bft_reg   <= 1'b0;
            dv_reg    <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            iss_reg   <= iss_next;
            wb_reg    <= wb_next;
            to_reg    <= to_next;
            stage_reg <= stage_next;
            bfv_reg   <= bfv_next;
            bft_reg   <= bft_next;
            dv_reg    <= dv_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // Dual-port RAM: port A reads (issue/dump), port B writes (load/write-back).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        rd_q <= mem[rd_addr];
    end

`ifdef PERF_CNT_EN
    logic [15:0] perf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_reg <= '0;
        end else if (state_reg == ST_IDLE && state_next == ST_ISSUE) begin
            perf_reg <= '0;
        end else if (state_reg == ST_ISSUE || state_reg == ST_WAIT_WB) begin
            perf_reg <= perf_reg + 1'b1;
        end
    end

    assign perf_cycles = perf_reg;
`endif

    // Data outputs are gated so that reset clears them without waiting for a clock.
    assign bus.ld_ready   = (state_reg == ST_LOAD);
    assign bus.bf_valid   = bfv_reg;
    assign bus.bf_data    = bfv_reg ? rd_q : '0;
    assign bus.bf_type    = bft_reg;
    assign bus.bf_stage   = stage_reg;
    assign bus.dump_valid = dv_reg;
    assign bus.dump_data  = dv_reg ? rd_q : '0;
    assign busy           = (state_reg != ST_IDLE);
    assign done           = done_reg;
    assign err            = err_reg;

endmodule

// File: tb/tb_ntt_poly_feeder.sv
// Directed bench for ntt_poly_feeder: memory/issue-order model plus a per-cycle output checker.
module tb_ntt_poly_feeder;

    typedef struct packed {
        logic [95:0] d;
        logic        t;
        logic [2:0]  s;
    } bf_exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_load, start_run, start_dump;
    logic [2:0] run_stage;
    logic       busy, done, err;

    int tests = 0;
    int fails = 0;
    int dump_beats = 0;

    logic [95:0] model_mem [32];
    bf_exp_t     bf_exp_q [$];
    logic [95:0] dump_exp_q [$];
    bf_exp_t     mon_e;
    logic [95:0] mon_d;

    ntt_poly_feeder_if bus ();

    ntt_poly_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .start_load (start_load),
        .start_run  (start_run),
        .run_stage  (run_stage),
        .start_dump (start_dump),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue order straight from the layer definition: pair k -> j (0 inserted at log2 d), then j + d.
    function automatic int exp_addr(input int s, input int i);
        int d, lg, k, j;
        if (s >= 5) return i;
        d  = 16 >> s;
        lg = 4 - s;
        k  = i / 2;
        j  = ((k >> lg) << (lg + 1)) + (k % d);
        return j + (i % 2) * d;
    endfunction

    function automatic int exp_type(input int s, input int i);
        return (s >= 5) ? 0 : (i % 2);
    endfunction

    // Output checker: every bf beat and every accepted dump beat against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.bf_valid) begin
                if (bf_exp_q.size() == 0) begin
                    check("bf_unexpected", 96'd1, 96'd0);
                end else begin
                    mon_e = bf_exp_q.pop_front();
                    check("bf_data", bus.bf_data, mon_e.d);
                    check("bf_type", 96'(bus.bf_type), 96'(mon_e.t));
                    check("bf_stage", 96'(bus.bf_stage), 96'(mon_e.s));
                end
            end
            if (bus.dump_valid && bus.dump_ready) begin
                dump_beats++;
                if (dump_exp_q.size() == 0) begin
                    check("dump_unexpected", 96'd1, 96'd0);
                end else begin
                    mon_d = dump_exp_q.pop_front();
                    check("dump_data", bus.dump_data, mon_d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_issue_expect(input int s);
        bf_exp_t e;
        for (int i = 0; i < 32; i++) begin
            e.d = model_mem[exp_addr(s, i)];
            e.t = 1'(exp_type(s, i));
            e.s = 3'(s);
            bf_exp_q.push_back(e);
        end
    endtask

    task automatic load_words(input int base);
        for (int n = 0; n < 32; n++) model_mem[n] = {8{12'(n + base)}};
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        check("ld_ready_in_load", 96'(bus.ld_ready), 96'd1);
        for (int n = 0; n < 32; n++) begin
            if (n == 5) begin
                bus.ld_valid = 1'b0;
                tick();
            end
            bus.ld_valid = 1'b1;
            bus.ld_data  = model_mem[n];
            tick();
        end
        bus.ld_valid = 1'b0;
        check("load_done", 96'(done), 96'd1);
        check("load_ready_off", 96'(bus.ld_ready), 96'd0);
        tick();
        check("load_done_pulse", 96'(done), 96'd0);
    endtask

    task automatic dump_all(input bit toggle);
        bit          got = 1'b0;
        bit          stalled = 1'b0;
        logic [95:0] held = '0;
        dump_beats = 0;
        for (int n = 0; n < 32; n++) dump_exp_q.push_back(model_mem[n]);
        start_dump = 1'b1;
        tick();
        start_dump = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            if (stalled) begin
                check("dump_stall_valid", 96'(bus.dump_valid), 96'd1);
                check("dump_stall_data", bus.dump_data, held);
            end
            bus.dump_ready = toggle ? ((c % 2) == 0) : 1'b1;
            stalled = bus.dump_valid && !bus.dump_ready;
            held    = bus.dump_data;
            tick();
            if (done) got = 1'b1;
        end
        bus.dump_ready = 1'b0;
        check("dump_done", 96'(got), 96'd1);
        check("dump_beats", 96'(dump_beats), 96'd32);
        check("dump_queue_empty", 96'(dump_exp_q.size()), 96'd0);
    endtask

    task automatic run_layer(input int s, input bit invert);
        logic [95:0] snap [32];
        bit          pv [7];
        logic [95:0] pd [7];
        bit          got = 1'b0;
        int          wbs = 0;
        for (int i = 0; i < 32; i++) snap[i] = model_mem[i];
        for (int p = 0; p < 7; p++) begin
            pv[p] = 1'b0;
            pd[p] = '0;
        end
        push_issue_expect(s);
        run_stage = 3'(s);
        start_run = 1'b1;
        tick();
        start_run = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            for (int p = 6; p > 0; p--) begin
                pv[p] = pv[p-1];
                pd[p] = pd[p-1];
            end
            pv[0] = bus.bf_valid;
            pd[0] = invert ? ~bus.bf_data : bus.bf_data;
            bus.wb_valid = pv[6];
            bus.wb_data  = pd[6];
            if (pv[6]) wbs++;
            tick();
            if (done) got = 1'b1;
        end
        bus.wb_valid = 1'b0;
        check("run_done", 96'(got), 96'd1);
        check("run_idle", 96'(busy), 96'd0);
        check("run_wb_count", 96'(wbs), 96'd32);
        check("run_issue_all", 96'(bf_exp_q.size()), 96'd0);
        for (int i = 0; i < 32; i++) begin
            model_mem[exp_addr(s, i)] = invert ? ~snap[exp_addr(s, i)] : snap[exp_addr(s, i)];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  seen_done;
        rst = 1'b1;
        start_load = 1'b0; start_run = 1'b0; start_dump = 1'b0; run_stage = 3'd0;
        bus.ld_valid = 1'b0; bus.ld_data = '0;
        bus.wb_valid = 1'b0; bus.wb_data = '0;
        bus.dump_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", 96'(busy), 96'd0);
        check("rst_done", 96'(done), 96'd0);
        check("rst_err", 96'(err), 96'd0);
        check("rst_ld_ready", 96'(bus.ld_ready), 96'd0);
        check("rst_bf_valid", 96'(bus.bf_valid), 96'd0);
        check("rst_bf_data", bus.bf_data, 96'd0);
        check("rst_bf_stage", 96'(bus.bf_stage), 96'd0);
        check("rst_dump_valid", 96'(bus.dump_valid), 96'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 96'(busy), 96'd0);

        // Hand-derived pins on the order model.
        check("addr_s0_1", 96'(exp_addr(0, 1)), 96'd16);
        check("addr_s0_2", 96'(exp_addr(0, 2)), 96'd1);
        check("addr_s0_3", 96'(exp_addr(0, 3)), 96'd17);
        check("addr_s0_31", 96'(exp_addr(0, 31)), 96'd31);
        check("addr_s1_1", 96'(exp_addr(1, 1)), 96'd8);
        check("addr_s3_1", 96'(exp_addr(3, 1)), 96'd2);
        check("addr_s3_2", 96'(exp_addr(3, 2)), 96'd1);
        check("addr_s3_3", 96'(exp_addr(3, 3)), 96'd3);
        check("addr_s3_4", 96'(exp_addr(3, 4)), 96'd4);
        check("addr_s3_5", 96'(exp_addr(3, 5)), 96'd6);
        check("addr_s6_7", 96'(exp_addr(6, 7)), 96'd7);
        check("type_s6_7", 96'(exp_type(6, 7)), 96'd0);
        check("type_s0_3", 96'(exp_type(0, 3)), 96'd1);

        load_words(0);
        check("word5_pattern", model_mem[5], 96'h005005005005005005005005);
        dump_all(1'b0);

        run_layer(0, 1'b0);
        dump_all(1'b0);
        run_layer(3, 1'b0);
        run_layer(6, 1'b1);
        check("word2_inverted", model_mem[2], ~96'h002002002002002002002002);
        dump_all(1'b0);
        dump_all(1'b1);

        // Asynchronous reset in the middle of an issue burst.
        push_issue_expect(2);
        run_stage = 3'd2;
        start_run = 1'b1;
        tick();
        start_run = 1'b0;
        repeat (4) tick();
        #1 rst = 1'b1;
        #1;
        check("arst_bf_valid", 96'(bus.bf_valid), 96'd0);
        check("arst_bf_data", bus.bf_data, 96'd0);
        check("arst_busy", 96'(busy), 96'd0);
        bf_exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        load_words(200);
        dump_all(1'b0);

        // Invalid stage: error, no issue.
        run_stage = 3'd7;
        start_run = 1'b1;
        tick();
        start_run = 1'b0;
        check("stage7_err", 96'(err), 96'd1);
        check("stage7_busy", 96'(busy), 96'd0);
        cnt = 0;
        repeat (5) begin
            if (bus.bf_valid) cnt++;
            tick();
        end
        check("stage7_no_bf", 96'(cnt), 96'd0);

        do_reset();
        check("err_cleared", 96'(err), 96'd0);
        bus.wb_valid = 1'b1;
        tick();
        bus.wb_valid = 1'b0;
        check("stray_wb_err", 96'(err), 96'd1);

        // Write-back timeout.
        do_reset();
        push_issue_expect(1);
        run_stage = 3'd1;
        start_run = 1'b1;
        tick();
        start_run = 1'b0;
        seen_done = 1'b0;
        cnt = 0;
        for (int c = 0; c < 400; c++) begin
            cnt = c;
            if (!busy) break;
            if (done) seen_done = 1'b1;
            tick();
        end
        check("timeout_idle", 96'(busy), 96'd0);
        check("timeout_err", 96'(err), 96'd1);
        check("timeout_no_done", 96'(seen_done), 96'd0);
        check("timeout_len_ok", 96'(cnt >= 90 && cnt <= 100), 96'd1);
        check("timeout_issue_all", 96'(bf_exp_q.size()), 96'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
